itag_bist: RTL and testbench

- March-test BIST controller for the instruction-cache tag array.
- Drives the tag array's BIST port (test_mode, bist_enable, bist_icu_tag_addr/in/vld/we) and checks the read data and hit flag it returns.
- Sits beside the icache tag array.
- Started by the test/JTAG controller; reports done/fail plus the first failing address.

---
 rtl/itag_bist_if.sv | 28 ++
 rtl/itag_bist.sv | 181 ++++++++++++++++++
 tb/tb_itag_bist.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/itag_bist_if.sv
// Tag-array BIST port bundle: the controller drives the array side (master),
// the icache tag array returns read data and the hit flag (slave).
interface itag_bist_if #(
  parameter int ADDR_W = 9,
  parameter int TAG_W  = 18
);
  logic              test_mode;
  logic              bist_enable;
  logic [ADDR_W-1:0] bist_icu_tag_addr;
  logic [TAG_W-1:0]  bist_icu_tag_in;
  logic              bist_icu_tag_vld;
  logic              bist_icu_tag_we;
  logic [TAG_W-1:0]  itag_dout;
  logic              itag_vld;
  logic              itag_hit;

  modport master (
    output test_mode, bist_enable, bist_icu_tag_addr, bist_icu_tag_in,
           bist_icu_tag_vld, bist_icu_tag_we,
    input  itag_dout, itag_vld, itag_hit
  );

  modport slave (
    input  test_mode, bist_enable, bist_icu_tag_addr, bist_icu_tag_in,
           bist_icu_tag_vld, bist_icu_tag_we,
    output itag_dout, itag_vld, itag_hit
  );
endinterface

// File: rtl/itag_bist.sv
// March-test BIST controller for the icache tag array (W0^ / R0W1^ / R1W0v / R0^).
// Optional hit-flag checking during reads is enabled by defining ITAG_BIST_HIT_CHK_EN.
module itag_bist #(
  parameter int ADDR_W = 9,
  parameter int TAG_W  = 18
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              bist_start,
  itag_bist_if.master       arr,
  output logic              bist_done,
  output logic              bist_fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [1:0]        fail_elem
);

`ifdef ITAG_BIST_HIT_CHK_EN
  localparam logic HIT_CHK = 1'b1;
`else
  localparam logic HIT_CHK = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [3:0] {
    IDLE, SETUP, M0_W, M1_RD, M1_WR, M2_RD, M2_WR, M3_RD, M3_CHK, DONE, FAIL
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [TAG_W-1:0]  tag_q;
  logic              vld_q;
  logic              test_mode_q;
  logic              enable_q;
  logic              we_q;
  logic              chk_q;

  logic              exp_p1;
  logic              mismatch;
  logic [ADDR_W-1:0] cmp_addr;
  logic [1:0]        elem;

  // Read-cycle tag/vld: expected pattern when hit checking, else the next write pattern.
  function automatic logic [TAG_W:0] rd_pat(input logic exp1, input logic wr1);
    if (HIT_CHK) rd_pat = {{TAG_W{exp1}}, 1'b1};
    else         rd_pat = {(TAG_W+1){wr1}};
  endfunction

  always_comb begin
    exp_p1   = (state == M2_WR);
    elem     = 2'd0;
    case (state)
      M1_RD, M1_WR:  elem = 2'd1;
      M2_RD, M2_WR:  elem = 2'd2;
      M3_RD, M3_CHK: elem = 2'd3;
      default:       elem = 2'd0;
    endcase
    // M3 reads are pipelined, so the data present belongs to the previous address.
    cmp_addr = (state == M3_RD || state == M3_CHK) ? addr_q - 1'b1 : addr_q;
    mismatch = 1'b0;
    if (chk_q)
      mismatch = ({arr.itag_dout, arr.itag_vld} != {(TAG_W+1){exp_p1}}) ||
                 (HIT_CHK && (arr.itag_hit != exp_p1));
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state       <= IDLE;
      addr_q      <= '0;
      tag_q       <= '0;
      vld_q       <= 1'b0;
      test_mode_q <= 1'b0;
      enable_q    <= 1'b0;
      we_q        <= 1'b0;
      chk_q       <= 1'b0;
      bist_done   <= 1'b0;
      bist_fail   <= 1'b0;
      fail_addr   <= '0;
      fail_elem   <= '0;
    end else begin
      we_q  <= 1'b0;
      chk_q <= 1'b0;
      if (mismatch) begin
        state       <= FAIL;
        addr_q      <= '0;
        {tag_q, vld_q} <= '0;
        test_mode_q <= 1'b0;
        enable_q    <= 1'b0;
        bist_done   <= 1'b1;
        bist_fail   <= 1'b1;
        fail_addr   <= cmp_addr;
        fail_elem   <= elem;
      end else begin
        case (state)
          IDLE: if (bist_start) begin
            state       <= SETUP;
            test_mode_q <= 1'b1;
            enable_q    <= 1'b1;
            addr_q      <= '0;
          end
          SETUP: begin
            state <= M0_W;
            we_q  <= 1'b1;
            {tag_q, vld_q} <= '0;
          end
          M0_W: begin
            addr_q <= addr_q + 1'b1;
            if (addr_q == ADDR_MAX) begin
              state <= M1_RD;
              {tag_q, vld_q} <= rd_pat(1'b0, 1'b1);
            end else begin
              we_q <= 1'b1;
            end
          end
          M1_RD: begin
            state <= M1_WR;
            we_q  <= 1'b1;
            chk_q <= 1'b1;
            {tag_q, vld_q} <= '1;
          end
          M1_WR: begin
            if (addr_q == ADDR_MAX) begin
              state <= M2_RD;
              {tag_q, vld_q} <= rd_pat(1'b1, 1'b0);
            end else begin
              state  <= M1_RD;
              addr_q <= addr_q + 1'b1;
              {tag_q, vld_q} <= rd_pat(1'b0, 1'b1);
            end
          end
          M2_RD: begin
            state <= M2_WR;
            we_q  <= 1'b1;
            chk_q <= 1'b1;
            {tag_q, vld_q} <= '0;
          end
          M2_WR: begin
            if (addr_q == '0) begin
              state <= M3_RD;
              {tag_q, vld_q} <= rd_pat(1'b0, 1'b0);
            end else begin
              state  <= M2_RD;
              addr_q <= addr_q - 1'b1;
              {tag_q, vld_q} <= rd_pat(1'b1, 1'b0);
            end
          end
          M3_RD: begin
            addr_q <= addr_q + 1'b1;
            chk_q  <= 1'b1;
            if (addr_q == ADDR_MAX) state <= M3_CHK;
          end
          M3_CHK: begin
            state       <= DONE;
            addr_q      <= '0;
            {tag_q, vld_q} <= '0;
            test_mode_q <= 1'b0;
            enable_q    <= 1'b0;
            bist_done   <= 1'b1;
          end
          DONE, FAIL: if (!bist_start) begin
            state     <= IDLE;
            bist_done <= 1'b0;
            bist_fail <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign arr.test_mode         = test_mode_q;
  assign arr.bist_enable       = enable_q;
  assign arr.bist_icu_tag_addr = addr_q;
  assign arr.bist_icu_tag_in   = tag_q;
  assign arr.bist_icu_tag_vld  = vld_q;
  // The compare result arrives in the same cycle as the write, so the write is suppressed combinationally.
  assign arr.bist_icu_tag_we   = we_q & ~mismatch;

endmodule

// File: tb/tb_itag_bist.sv
// Bench for itag_bist: behavioural tag array with injectable faults and a result scoreboard.
module tb_itag_bist;
  localparam int ADDR_W = 9;
  localparam int TAG_W  = 18;

  logic              clk;
  logic              reset_l;
  logic              bist_start;
  logic              bist_done;
  logic              bist_fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [1:0]        fail_elem;

  itag_bist_if #(.ADDR_W(ADDR_W), .TAG_W(TAG_W)) arr ();

  itag_bist #(.ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .bist_start (bist_start),
    .arr        (arr.master),
    .bist_done  (bist_done),
    .bist_fail  (bist_fail),
    .fail_addr  (fail_addr),
    .fail_elem  (fail_elem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- array model with fault injection ----------------
  int f_tag5_idx = -1;
  int f_vld0_idx = -1;
  bit f_alias    = 1'b0;
  bit f_hit0     = 1'b0;
  int wr_count;

  logic [TAG_W:0] mem [1<<ADDR_W];

  function automatic logic [TAG_W:0] faulty(input int idx, input logic [TAG_W:0] v);
    logic [TAG_W:0] r;
    r = v;
    if (idx == f_tag5_idx) r[5+1] = 1'b1;
    if (idx == f_vld0_idx) r[0]   = 1'b0;
    return r;
  endfunction

  always @(posedge clk) begin
    if (arr.bist_enable) begin
      if (arr.bist_icu_tag_we) begin
        wr_count <= wr_count + 1;
        mem[arr.bist_icu_tag_addr] <= faulty(int'(arr.bist_icu_tag_addr),
                                             {arr.bist_icu_tag_in, arr.bist_icu_tag_vld});
        // decoder fault: a write to 0x011 also lands in 0x010
        if (f_alias && arr.bist_icu_tag_addr == 9'h011)
          mem[9'h010] <= faulty(16, {arr.bist_icu_tag_in, arr.bist_icu_tag_vld});
      end
      {arr.itag_dout, arr.itag_vld} <= mem[arr.bist_icu_tag_addr];
      arr.itag_hit <= !f_hit0 && mem[arr.bist_icu_tag_addr][0] &&
                      (mem[arr.bist_icu_tag_addr][TAG_W:1] == arr.bist_icu_tag_in);
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [12:0] res;     // {done, fail, elem, addr}
    int          cycles;
    int          writes;
  } exp_t;

  typedef struct {
    logic [12:0] res;
    int          cycles;
    int          writes;
    logic        tm;
    logic [43:0] post;
  } obs_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [43:0] all_outs();
    return {arr.test_mode, arr.bist_enable, arr.bist_icu_tag_addr, arr.bist_icu_tag_in,
            arr.bist_icu_tag_vld, arr.bist_icu_tag_we, bist_done, bist_fail, fail_addr, fail_elem};
  endfunction

  task automatic clear_faults();
    f_tag5_idx = -1;
    f_vld0_idx = -1;
    f_alias    = 1'b0;
    f_hit0     = 1'b0;
  endtask

  // Starts a run, waits (bounded) for bist_done, captures the outcome, then releases bist_start.
  task automatic run_bist(input int drop_at, output obs_t o);
    int n;
    int w0;
    o.res = '0; o.cycles = -1; o.writes = 0; o.tm = 1'b1; o.post = '1;
    w0 = wr_count;
    @(negedge clk) bist_start = 1'b1;
    n = 0;
    while (!arr.test_mode && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (!bist_done && n < 5000) begin
      @(negedge clk);
      n++;
      if (n == drop_at) bist_start = 1'b0;
    end
    o.cycles = n;
    o.res    = {bist_done, bist_fail, fail_elem, fail_addr};
    o.tm     = arr.test_mode;
    o.writes = wr_count - w0;
    bist_start = 1'b0;
    @(negedge clk);
    o.post = all_outs();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    total++;
    if (all_outs() !== '0) begin
      bad++; $display("FAIL reset_outs: got %h want 0", all_outs());
    end
    @(negedge clk) reset_l = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (all_outs() !== '0) begin
      bad++; $display("FAIL idle_outs: got %h want 0", all_outs());
    end
  endtask

  task automatic test_clean_pass();
    exp_t e; obs_t o;
    clear_faults();
    exp_q.push_back('{res: {1'b1, 1'b0, 2'd0, 9'h000}, cycles: 3074, writes: 1536});
    run_bist(0, o);
    e = exp_q.pop_front();
    total++;
    if (o.res !== e.res) begin bad++; $display("FAIL clean_res: got %h want %h", o.res, e.res); end
    total++;
    if (o.cycles != e.cycles) begin bad++; $display("FAIL clean_cycles: got %0d want %0d", o.cycles, e.cycles); end
    total++;
    if (o.writes != e.writes) begin bad++; $display("FAIL clean_writes: got %0d want %0d", o.writes, e.writes); end
    total++;
    if (o.tm !== 1'b0) begin bad++; $display("FAIL clean_tm_done: got %b want 0", o.tm); end
    total++;
    if (o.post !== '0) begin bad++; $display("FAIL clean_clear: got %h want 0", o.post); end
  endtask

  task automatic test_tag_stuck();
    exp_t e; obs_t o;
    clear_faults();
    f_tag5_idx = 'h0A3;
    // stuck bit corrupts the P0 written by M0; caught by the first M1 compare
    exp_q.push_back('{res: {1'b1, 1'b1, 2'd1, 9'h0A3}, cycles: -1, writes: -1});
    run_bist(0, o);
    e = exp_q.pop_front();
    total++;
    if (o.res !== e.res) begin bad++; $display("FAIL tag5_res: got %h want %h", o.res, e.res); end
    total++;
    if (o.post !== '0) begin bad++; $display("FAIL tag5_clear: got %h want 0", o.post); end
  endtask

  task automatic test_vld_stuck();
    exp_t e; obs_t o;
    clear_faults();
    f_vld0_idx = 'h1FF;
    // M0 and M1 writes only: the failing M2 compare must not write
    exp_q.push_back('{res: {1'b1, 1'b1, 2'd2, 9'h1FF}, cycles: 1+512+1024+2, writes: 1024});
    run_bist(0, o);
    e = exp_q.pop_front();
    total++;
    if (o.res !== e.res) begin bad++; $display("FAIL vld0_res: got %h want %h", o.res, e.res); end
    total++;
    if (o.writes != e.writes) begin bad++; $display("FAIL vld0_writes: got %0d want %0d", o.writes, e.writes); end
    total++;
    if (o.cycles != e.cycles) begin bad++; $display("FAIL vld0_cycles: got %0d want %0d", o.cycles, e.cycles); end
  endtask

  task automatic test_alias();
    exp_t e; obs_t o;
    clear_faults();
    f_alias = 1'b1;
    // M2 writing P0 at 0x011 clobbers 0x010 before it is read descending
    exp_q.push_back('{res: {1'b1, 1'b1, 2'd2, 9'h010}, cycles: -1, writes: -1});
    run_bist(0, o);
    e = exp_q.pop_front();
    total++;
    if (o.res !== e.res) begin bad++; $display("FAIL alias_res: got %h want %h", o.res, e.res); end
  endtask

  task automatic test_start_drop();
    exp_t e; obs_t o;
    clear_faults();
    exp_q.push_back('{res: {1'b1, 1'b0, 2'd0, 9'h000}, cycles: 3074, writes: 1536});
    run_bist(100, o);
    e = exp_q.pop_front();
    total++;
    if (o.res !== e.res) begin bad++; $display("FAIL drop_res: got %h want %h", o.res, e.res); end
    total++;
    if (o.cycles != e.cycles) begin bad++; $display("FAIL drop_cycles: got %0d want %0d", o.cycles, e.cycles); end
    total++;
    if (o.post !== '0) begin bad++; $display("FAIL drop_clear: got %h want 0", o.post); end
  endtask

  task automatic test_midrun_reset();
    exp_t e; obs_t o;
    int n;
    clear_faults();
    @(negedge clk) bist_start = 1'b1;
    n = 0;
    while (!arr.test_mode && n < 10) begin @(negedge clk); n++; end
    repeat (1000) @(negedge clk);
    total++;
    if (arr.test_mode !== 1'b1) begin bad++; $display("FAIL midrun_active: got %b want 1", arr.test_mode); end
    #2 reset_l = 1'b0;
    #1;
    total++;
    if (all_outs() !== '0) begin bad++; $display("FAIL midrun_reset_outs: got %h want 0", all_outs()); end
    @(negedge clk);
    bist_start = 1'b0;
    reset_l    = 1'b1;
    exp_q.push_back('{res: {1'b1, 1'b0, 2'd0, 9'h000}, cycles: 3074, writes: 1536});
    run_bist(0, o);
    e = exp_q.pop_front();
    total++;
    if (o.res !== e.res) begin bad++; $display("FAIL rerun_res: got %h want %h", o.res, e.res); end
    total++;
    if (o.cycles != e.cycles) begin bad++; $display("FAIL rerun_cycles: got %0d want %0d", o.cycles, e.cycles); end
  endtask

  task automatic test_hit_chk();
    exp_t e; obs_t o;
    clear_faults();
    f_hit0 = 1'b1;
`ifdef ITAG_BIST_HIT_CHK_EN
    exp_q.push_back('{res: {1'b1, 1'b1, 2'd2, 9'h1FF}, cycles: -1, writes: -1});
`else
    exp_q.push_back('{res: {1'b1, 1'b0, 2'd0, 9'h000}, cycles: -1, writes: -1});
`endif
    run_bist(0, o);
    e = exp_q.pop_front();
    total++;
    if (o.res !== e.res) begin bad++; $display("FAIL hit0_res: got %h want %h", o.res, e.res); end
  endtask

  initial begin
    reset_l    = 1'b0;
    bist_start = 1'b0;
    clear_faults();
    repeat (3) @(negedge clk);
    test_reset();
    test_clean_pass();
    test_tag_stuck();
    test_vld_stuck();
    test_alias();
    test_start_drop();
    test_midrun_reset();
    test_hit_chk();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
